// File: rtl/router_reg_gen.sv
// Packet register stage of the 1xN router. Latches the header, streams payload
// to the destination FIFO, holds one byte across a FIFO-full stall, and checks
// the packet check byte and payload length. Counts failing packets.
module router_reg_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 2,
    parameter int NUM_PORTS  = 3,
    parameter int CHECK_MODE = 0,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  rst_int_reg,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err,
    output logic                  len_err,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int              LEN_W   = DATA_WIDTH - ADDR_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] header_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] pkt_check;
    logic [LEN_W-1:0]      pay_cnt;
    logic                  chk_done;

    logic addr_ok;
    logic capture_check;
    logic acc_mismatch;
    logic len_mismatch;

    // Running check function: XOR parity or modular sum, fixed at elaboration.
    function automatic logic [DATA_WIDTH-1:0] combine(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        if (CHECK_MODE == 1) begin
            return a + b;
        end
        return a ^ b;
    endfunction

    // Decode address validity, check-byte capture moment and packet verdicts.
    always_comb begin
        addr_ok       = 32'(data_in[ADDR_BITS-1:0]) < 32'(NUM_PORTS);
        capture_check = (ld_state && !pkt_valid && !fifo_full) ||
                        (laf_state && low_pkt_valid && !parity_done);
        acc_mismatch  = (acc != pkt_check);
        len_mismatch  = (pay_cnt != header_reg[DATA_WIDTH-1:ADDR_BITS]);
    end

    // Header register: only a header with a routable address is kept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            header_reg <= '0;
        end else if (detect_add && pkt_valid && addr_ok) begin
            header_reg <= data_in;
        end
    end

    // Output byte selection, parking the byte that arrived while the FIFO was full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout     <= '0;
            hold_reg <= '0;
        end else if (lfd_state) begin
            dout <= header_reg;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (ld_state && fifo_full) begin
            hold_reg <= data_in;
        end else if (laf_state) begin
            dout <= hold_reg;
        end
    end

    // Accumulate header and payload into the check value and count payload bytes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc     <= '0;
            pay_cnt <= '0;
        end else if (detect_add) begin
            acc     <= '0;
            pay_cnt <= '0;
        end else if (lfd_state) begin
            acc <= combine(acc, header_reg);
        end else if (ld_state && pkt_valid && !full_state) begin
            acc     <= combine(acc, data_in);
            pay_cnt <= pay_cnt + LEN_W'(1);
        end
    end

    // Flag the end of the packet stream; the FSM acknowledges via rst_int_reg.
    always_ff @(posedge clk) begin
        if (!rst) begin
            low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid <= 1'b1;
        end
    end

    // Capture the check byte and mark it available.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_check   <= '0;
            parity_done <= 1'b0;
        end else begin
            if (capture_check) begin
                pkt_check <= data_in;
            end
            if (detect_add) begin
                parity_done <= 1'b0;
            end else if (capture_check) begin
                parity_done <= 1'b1;
            end
        end
    end

    // Evaluate the packet once after the check byte is in, and count failures.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err      <= 1'b0;
            len_err  <= 1'b0;
            chk_done <= 1'b0;
            err_cnt  <= '0;
        end else if (detect_add) begin
            err      <= 1'b0;
            len_err  <= 1'b0;
            chk_done <= 1'b0;
        end else if (parity_done && !chk_done) begin
            err      <= acc_mismatch;
            len_err  <= len_mismatch;
            chk_done <= 1'b1;
            if ((acc_mismatch || len_mismatch) && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule
